dmem_bridge: RTL

- Sits between the pipelined core's memory-stage data port and the external data-memory bus.
- Posts stores into a small write buffer so they retire without stalling.
- Turns single-cycle loads into req/ack bus transactions and raises stallM until load data is ready.
- Keeps program order (all buffered writes drain before a read is issued) and bounds bus waits with a timeout.

---
 rtl/dmem_bridge_pkg.sv | 25 ++
 rtl/dmem_bridge_wbuf_fifo.sv | 42 ++++
 rtl/dmem_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the memory-stage data bridge.
package dmem_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam logic [ADDR_W-1:0] WORD_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/dmem_bridge_wbuf_fifo.sv
// Posted-store buffer: DEPTH entries of {addr,data}, push/pop on the same edge allowed.
module wbuf_fifo
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_wdata,
  input  logic      i_pop,
  output wb_entry_t o_head_c,
  output logic      o_full_c,
  output logic      o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  wb_entry_t   r_mem [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty_c = (r_wptr == r_rptr);
  assign o_full_c  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head_c  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full_c) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop && !o_empty_c) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full_c) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core M-stage data port to a req/ack bus: posted stores, stalling loads, bus timeout.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_bus_req, w_req_nxt;
  logic              r_bus_we, w_we_nxt;
  logic [ADDR_W-1:0] r_bus_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_bus_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_readdata, w_rdata_nxt;
  logic              r_rd_done, w_rd_done_nxt;
  logic              r_bus_err, w_err_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic      w_push, w_pop, w_full, w_empty, w_timeout;
  wb_entry_t w_head, w_push_entry;

  assign w_push       = memwriteM && !w_full;
  assign w_push_entry = '{addr: aluoutM, data: writedataM};
  // The wait that would take the counter to TIMEOUT is the abort cycle; an ack there still wins.
  assign w_timeout    = !bus_ack && (r_cnt == CNT_LAST);

  assign stallM    = (memwriteM && w_full) || (memreadM && !r_rd_done);
  assign readdataM = r_readdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_err   = r_bus_err;

  wbuf_fifo #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wdata   (w_push_entry),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_readdata  <= '0;
      r_rd_done   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_req_nxt;
      r_bus_we    <= w_we_nxt;
      r_bus_addr  <= w_addr_nxt;
      r_bus_wdata <= w_wdata_nxt;
      r_readdata  <= w_rdata_nxt;
      r_rd_done   <= w_rd_done_nxt;
      r_bus_err   <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Writes drain before any read so loads always observe earlier stores.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_bus_req;
    w_we_nxt      = r_bus_we;
    w_addr_nxt    = r_bus_addr;
    w_wdata_nxt   = r_bus_wdata;
    w_rdata_nxt   = r_readdata;
    w_rd_done_nxt = 1'b0;
    w_err_nxt     = r_bus_err;
    w_pop         = 1'b0;
    w_cnt_nxt     = (r_bus_req && !bus_ack) ? r_cnt + CNT_W'(1) : r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_WR;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = word_align(w_head.addr);
          w_wdata_nxt = w_head.data;
          w_cnt_nxt   = '0;
        end else if (memreadM && !r_rd_done) begin
          w_state_nxt = ST_RD;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = word_align(aluoutM);
          w_cnt_nxt   = '0;
        end
      end
      ST_WR: begin
        if (bus_ack || w_timeout) begin
          w_pop       = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
          if (!bus_ack) w_err_nxt = 1'b1;
        end
      end
      ST_RD: begin
        if (bus_ack) begin
          w_rdata_nxt   = bus_rdata;
          w_rd_done_nxt = 1'b1;
          w_req_nxt     = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (w_timeout) begin
          w_rdata_nxt   = TIMEOUT_RDATA;
          w_rd_done_nxt = 1'b1;
          w_err_nxt     = 1'b1;
          w_req_nxt     = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
